// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: memop codes, MMIO map, arbiter states.
// Latency: none; this package only holds constants and types.
// Backpressure: none; no logic here.
package dmem_pkg;

   // memop encoding used on the dmem port
   localparam logic [2:0] MOP_W  = 3'b000;
   localparam logic [2:0] MOP_B  = 3'b001;
   localparam logic [2:0] MOP_H  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b101;
   localparam logic [2:0] MOP_HU = 3'b110;

   // addr[31:28] value selecting the MMIO device region
   localparam logic [3:0] DEV_NIBBLE = 4'ha;

   // MMIO register addresses
   localparam logic [31:0] MMIO_LED   = 32'ha000_0400;
   localparam logic [31:0] MMIO_SW    = 32'ha000_0500;
   localparam logic [31:0] MMIO_BT    = 32'ha000_0600;
   localparam logic [31:0] MMIO_PORT  = 32'ha000_03f8;
   localparam logic [31:0] MMIO_TIMER = 32'ha000_0048;

   // arbiter FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants the lone requester, or on a tie the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic sel
);

   // tie goes to the master that did not win the previous grant
   always_comb begin
      valid = req0 | req1;
      sel   = 1'b0;
      if (req0 && req1) begin
         sel = ~last;
      end else if (req1) begin
         sel = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between CPU (m0) and DMA/debug (m1), round-robin, one access per grant.
// Latency: req sampled in cycle N -> gnt + mem_en in N+1 -> rvalid + rdata in N+2; one access per 2 cycles.
// Backpressure: losing master holds req; worst-case wait is one access. Optional DMEM_ARB_DEV_PROTECT_EN blocks m1 MMIO accesses.
module dmem_arbiter #(
   parameter int          AW         = 32,
   parameter int          DW         = 32,
   parameter logic [3:0]  DEV_NIBBLE = dmem_pkg::DEV_NIBBLE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_we,
   input  logic [2:0]    m0_op,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_we,
   input  logic [2:0]    m1_op,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [2:0]    mem_op,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   import dmem_pkg::*;

`ifdef DMEM_ARB_DEV_PROTECT_EN
   localparam logic PROTECT = 1'b1;
`else
   localparam logic PROTECT = 1'b0;
`endif

   arb_state_t    state, state_nxt;
   logic          sel, sel_nxt;
   logic          last, last_nxt;
   logic          blk, blk_nxt;
   logic          pick_vld, pick_sel, dev_hit;

   logic          mem_en_nxt, mem_we_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic [2:0]    mem_op_nxt;
   logic [DW-1:0] mem_wdata_nxt;
   logic          gnt0_nxt, gnt1_nxt, rv0_nxt, rv1_nxt, err_nxt;
   logic          gnt0_q, gnt1_q, rv0_q, rv1_q, err_q;
   logic [DW-1:0] rdata0_q, rdata1_q, resp_dat;

   rr_pick2 u_pick (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (last),
      .valid (pick_vld),
      .sel   (pick_sel)
   );

   assign dev_hit = (m1_addr[AW-1 -: 4] == DEV_NIBBLE);

   // a blocked access never reaches dmem, so its response data is forced to zero
   assign resp_dat = blk ? '0 : mem_rdata;

   // next state and next registered outputs; IDLE and RESP both arbitrate
   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      last_nxt      = last;
      blk_nxt       = blk;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = '0;
      mem_op_nxt    = '0;
      mem_wdata_nxt = '0;
      gnt0_nxt      = 1'b0;
      gnt1_nxt      = 1'b0;
      rv0_nxt       = 1'b0;
      rv1_nxt       = 1'b0;
      err_nxt       = 1'b0;
      case (state)
         ST_ISSUE: begin
            state_nxt = ST_RESP;
            last_nxt  = sel;
            rv0_nxt   = ~sel;
            rv1_nxt   = sel;
            err_nxt   = blk;
         end
         default: begin
            state_nxt = ST_IDLE;
            blk_nxt   = 1'b0;
            if (pick_vld) begin
               state_nxt = ST_ISSUE;
               sel_nxt   = pick_sel;
               blk_nxt   = PROTECT & pick_sel & dev_hit;
               gnt0_nxt  = ~pick_sel;
               gnt1_nxt  = pick_sel;
               if (!blk_nxt) begin
                  mem_en_nxt = 1'b1;
                  if (pick_sel) begin
                     mem_we_nxt    = m1_we;
                     mem_addr_nxt  = m1_addr;
                     mem_op_nxt    = m1_op;
                     mem_wdata_nxt = m1_wdata;
                  end else begin
                     mem_we_nxt    = m0_we;
                     mem_addr_nxt  = m0_addr;
                     mem_op_nxt    = m0_op;
                     mem_wdata_nxt = m0_wdata;
                  end
               end
            end
         end
      endcase
   end

   // state, arbitration history and registered outputs; reset aborts any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel       <= 1'b0;
         last      <= 1'b1;
         blk       <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_op    <= '0;
         mem_wdata <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rv0_q     <= 1'b0;
         rv1_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         last      <= last_nxt;
         blk       <= blk_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_op    <= mem_op_nxt;
         mem_wdata <= mem_wdata_nxt;
         gnt0_q    <= gnt0_nxt;
         gnt1_q    <= gnt1_nxt;
         rv0_q     <= rv0_nxt;
         rv1_q     <= rv1_nxt;
         err_q     <= err_nxt;
      end
   end

   // keep the last response per master so rdata holds between rvalids
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state == ST_RESP) begin
         if (sel) begin
            rdata1_q <= resp_dat;
         end else begin
            rdata0_q <= resp_dat;
         end
      end
   end

   // dmem data only arrives in RESP, so it is passed straight through in that cycle
   assign m0_rdata  = (state == ST_RESP && !sel) ? resp_dat : rdata0_q;
   assign m1_rdata  = (state == ST_RESP &&  sel) ? resp_dat : rdata1_q;
   assign m0_gnt    = gnt0_q;
   assign m1_gnt    = gnt1_q;
   assign m0_rvalid = rv0_q;
   assign m1_rvalid = rv1_q;
   assign m1_err    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency dmem stub.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: masters drop req right after seeing their grant unless a test holds them.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic [2:0]  m0_op = '0;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic [2:0]  m1_op = '0;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_op;
   logic [31:0] mem_rdata = '0;
   logic [31:0] rd_next = '0;

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.AW(32), .DW(32), .DEV_NIBBLE(4'ha)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_op(m0_op), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_op(m1_op), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_op(mem_op),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // dmem stub: read data appears the cycle after mem_en
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= rd_next;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      checks++;
      if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, mem_en, mem_we} !== 7'b0)
         begin errors++; $display("FAIL reset_ctl got %b expected 0000000", {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, mem_en, mem_we}); end
      checks++;
      if ((m0_rdata | m1_rdata | mem_addr | mem_wdata) !== 32'h0 || mem_op !== 3'b0)
         begin errors++; $display("FAIL reset_data got m0_rdata=%h m1_rdata=%h mem_addr=%h mem_wdata=%h mem_op=%b expected all 0", m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_op); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en} !== 3'b0)
         begin errors++; $display("FAIL reset_idle got %b expected 000", {m0_gnt, m1_gnt, mem_en}); end
   endtask

   task automatic test_single_read;
      m0_addr = 32'h10; m0_op = MOP_W; m0_we = 1'b0; rd_next = 32'hDEADBEEF;
      m0_req = 1'b1;
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10)
         begin errors++; $display("FAIL rd_issue got gnt0,gnt1,en,we=%b addr=%h expected 1010 addr=00000010", {m0_gnt, m1_gnt, mem_en, mem_we}, mem_addr); end
      m0_req = 1'b0;
      step();
      checks++;
      if ({m0_rvalid, m1_rvalid, mem_en} !== 3'b100 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'h0)
         begin errors++; $display("FAIL rd_resp got rv0,rv1,en=%b m0_rdata=%h m1_rdata=%h expected 100 deadbeef 00000000", {m0_rvalid, m1_rvalid, mem_en}, m0_rdata, m1_rdata); end
      step();
      checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF)
         begin errors++; $display("FAIL rd_hold got rv0=%b m0_rdata=%h expected 0 deadbeef", m0_rvalid, m0_rdata); end
   endtask

   task automatic test_both_from_reset;
      rst = 1'b1;
      step();
      rst = 1'b0;
      m0_addr = 32'h20; m0_op = MOP_H; m1_addr = 32'h30; m1_op = MOP_B;
      rd_next = 32'h1111_1111;
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en} !== 3'b101 || mem_addr !== 32'h20 || mem_op !== MOP_H)
         begin errors++; $display("FAIL tie_first got gnt0,gnt1,en=%b addr=%h op=%b expected 101 00000020 010", {m0_gnt, m1_gnt, mem_en}, mem_addr, mem_op); end
      m0_req = 1'b0;
      step();
      checks++;
      if ({m0_rvalid, m1_gnt, mem_en} !== 3'b100 || m0_rdata !== 32'h1111_1111)
         begin errors++; $display("FAIL tie_resp0 got rv0,gnt1,en=%b m0_rdata=%h expected 100 11111111", {m0_rvalid, m1_gnt, mem_en}, m0_rdata); end
      rd_next = 32'h2222_2222;
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en} !== 3'b011 || mem_addr !== 32'h30 || mem_op !== MOP_B)
         begin errors++; $display("FAIL tie_second got gnt0,gnt1,en=%b addr=%h op=%b expected 011 00000030 001", {m0_gnt, m1_gnt, mem_en}, mem_addr, mem_op); end
      m1_req = 1'b0;
      step();
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h2222_2222 || m0_rdata !== 32'h1111_1111)
         begin errors++; $display("FAIL tie_resp1 got rv0,rv1=%b m1_rdata=%h m0_rdata=%h expected 01 22222222 11111111", {m0_rvalid, m1_rvalid}, m1_rdata, m0_rdata); end
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid} !== 5'b0)
         begin errors++; $display("FAIL tie_idle got %b expected 00000", {m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid}); end
   endtask

   task automatic test_back_to_back;
      logic [4:0]  exp;
      logic [31:0] exp_addr;
      m0_addr = 32'h200; m0_op = MOP_W; m1_addr = 32'h300; m1_op = MOP_W;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         // even cycles issue, odd cycles respond; grants alternate starting with m0
         exp = {(i % 2 == 0) && ((i / 2) % 2 == 0), (i % 2 == 0) && ((i / 2) % 2 == 1),
                (i % 2 == 0), (i % 2 == 1) && ((i / 2) % 2 == 0), (i % 2 == 1) && ((i / 2) % 2 == 1)};
         exp_addr = (i % 2 == 1) ? 32'h0 : (((i / 2) % 2 == 0) ? 32'h200 : 32'h300);
         checks++;
         if ({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid} !== exp || mem_addr !== exp_addr)
            begin errors++; $display("FAIL b2b_cycle%0d got gnt0,gnt1,en,rv0,rv1=%b addr=%h expected %b %h", i, {m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid}, mem_addr, exp, exp_addr); end
         if (i == 11) begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
      end
      step();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en} !== 3'b0)
         begin errors++; $display("FAIL b2b_drain got %b expected 000", {m0_gnt, m1_gnt, mem_en}); end
   endtask

   task automatic test_write_m1;
      m1_addr = 32'h100; m1_op = MOP_W; m1_we = 1'b1; m1_wdata = 32'h12345678;
      m1_req = 1'b1;
      step();
      checks++;
      if ({m1_gnt, m0_gnt, mem_en, mem_we} !== 4'b1011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h100)
         begin errors++; $display("FAIL wr_issue got gnt1,gnt0,en,we=%b wdata=%h addr=%h expected 1011 12345678 00000100", {m1_gnt, m0_gnt, mem_en, mem_we}, mem_wdata, mem_addr); end
      m1_req = 1'b0;
      step();
      checks++;
      if ({m1_rvalid, mem_en, mem_we} !== 3'b100 || mem_wdata !== 32'h0 || mem_addr !== 32'h0)
         begin errors++; $display("FAIL wr_resp got rv1,en,we=%b wdata=%h addr=%h expected 100 00000000 00000000", {m1_rvalid, mem_en, mem_we}, mem_wdata, mem_addr); end
      m1_we = 1'b0;
      step();
   endtask

   task automatic test_reset_mid;
      // abort during ISSUE: no response must follow
      m0_addr = 32'h40; m0_op = MOP_W; rd_next = 32'h5555_5555;
      m0_req = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({m0_gnt, mem_en} !== 2'b00)
         begin errors++; $display("FAIL rst_issue got gnt0,en=%b expected 00", {m0_gnt, mem_en}); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m0_req = 1'b0;
      step();
      checks++;
      if ({m0_rvalid, m1_rvalid, mem_en} !== 3'b000)
         begin errors++; $display("FAIL rst_norv got rv0,rv1,en=%b expected 000", {m0_rvalid, m1_rvalid, mem_en}); end
      // reset while in RESP after an m0 access
      m0_req = 1'b1;
      step();
      m0_req = 1'b0;
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({m0_rvalid, m0_gnt, mem_en} !== 3'b000 || m0_rdata !== 32'h0)
         begin errors++; $display("FAIL rst_resp got rv0,gnt0,en=%b m0_rdata=%h expected 000 00000000", {m0_rvalid, m0_gnt, mem_en}, m0_rdata); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      // m0 was served last before reset, yet a tie must go to m0 again
      m0_addr = 32'h44; m1_addr = 32'h48; rd_next = 32'h6666_6666;
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10 || mem_addr !== 32'h44)
         begin errors++; $display("FAIL rst_tie got gnt0,gnt1=%b addr=%h expected 10 00000044", {m0_gnt, m1_gnt}, mem_addr); end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      step();
   endtask

   task automatic test_device;
      m1_addr = MMIO_LED; m1_we = 1'b1; m1_op = MOP_W; m1_wdata = 32'hCAFE_F00D;
      rd_next = 32'h7777_7777;
      m1_req = 1'b1;
      step();
`ifdef DMEM_ARB_DEV_PROTECT_EN
      checks++;
      if ({m1_gnt, mem_en, mem_we} !== 3'b100)
         begin errors++; $display("FAIL dev_issue got gnt1,en,we=%b expected 100", {m1_gnt, mem_en, mem_we}); end
      m1_req = 1'b0;
      step();
      checks++;
      if ({m1_rvalid, m1_err} !== 2'b11 || m1_rdata !== 32'h0)
         begin errors++; $display("FAIL dev_resp got rv1,err=%b m1_rdata=%h expected 11 00000000", {m1_rvalid, m1_err}, m1_rdata); end
`else
      checks++;
      if ({m1_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== MMIO_LED)
         begin errors++; $display("FAIL dev_issue got gnt1,en,we=%b addr=%h expected 111 a0000400", {m1_gnt, mem_en, mem_we}, mem_addr); end
      m1_req = 1'b0;
      step();
      checks++;
      if ({m1_rvalid, m1_err} !== 2'b10 || m1_rdata !== 32'h7777_7777)
         begin errors++; $display("FAIL dev_resp got rv1,err=%b m1_rdata=%h expected 10 77777777", {m1_rvalid, m1_err}, m1_rdata); end
`endif
      m1_we = 1'b0;
      step();
      checks++;
      if ({m1_rvalid, m1_err} !== 2'b00)
         begin errors++; $display("FAIL dev_clear got rv1,err=%b expected 00", {m1_rvalid, m1_err}); end
      // m0 is never blocked from the device region
      m0_addr = MMIO_LED; m0_we = 1'b0; rd_next = 32'h0000_0ABC;
      m0_req = 1'b1;
      step();
      checks++;
      if ({m0_gnt, mem_en} !== 2'b11 || mem_addr !== MMIO_LED)
         begin errors++; $display("FAIL dev_m0_issue got gnt0,en=%b addr=%h expected 11 a0000400", {m0_gnt, mem_en}, mem_addr); end
      m0_req = 1'b0;
      step();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_0ABC)
         begin errors++; $display("FAIL dev_m0_resp got rv0=%b m0_rdata=%h expected 1 00000abc", m0_rvalid, m0_rdata); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_both_from_reset();
      test_back_to_back();
      test_write_m1();
      test_reset_mid();
      test_device();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
